// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the TinyChip program-counter sequencer.
// PC_SEQ_BOUNDS_EN widens the fault vector with a PC range-check bit.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        SEQ  = 3'd0,
        JMP  = 3'd1,
        BR   = 3'd2,
        CALL = 3'd3,
        RET  = 3'd4,
        HOLD = 3'd5
    } pc_op_e;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } pc_state_e;

    localparam int FAULT_OVF = 0;
    localparam int FAULT_UNF = 1;
    localparam int FAULT_BND = 2;

`ifdef PC_SEQ_BOUNDS_EN
    localparam int FAULT_W = 3;
`else
    localparam int FAULT_W = 2;
`endif

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: a small LIFO; push is ignored when full, pop when empty.
module pc_ras #(
    parameter  int W     = 9,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     data_i,
    output logic [W-1:0]     data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [IDX_W-1:0] wr_idx_s;
    logic [IDX_W-1:0] rd_idx_s;

    // Write slot is the next free entry, read slot is the current top.
    always_comb begin
        wr_idx_s = IDX_W'(count_q);
        rd_idx_s = IDX_W'(count_q - CNT_W'(1));
    end

    assign data_o  = mem_q[rd_idx_s];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == {CNT_W{1'b0}});

    // Stack storage and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else if (push_i && !full_o) begin
            mem_q[wr_idx_s] <= data_i;
            count_q         <= count_q + CNT_W'(1);
        end else if (pop_i && !empty_o) begin
            count_q <= count_q - CNT_W'(1);
        end else begin
            count_q <= count_q;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with SEQ/JMP/BR/CALL/RET, a return-address stack and sticky halting faults.
// Define PC_SEQ_BOUNDS_EN to add the PC_LIMIT range check (fault[2]).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int          PC_W      = 9,
    parameter int          OFF_W     = 6,
    parameter int          RAS_DEPTH = 4,
    parameter int          RESET_PC  = 0
`ifdef PC_SEQ_BOUNDS_EN
    ,
    parameter int unsigned PC_LIMIT  = (1 << PC_W) - 1
`endif
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic [2:0]                       op,
    input  logic [PC_W-1:0]                  target,
    input  logic [OFF_W-1:0]                 offset,
    input  logic                             cond,
    output logic [PC_W-1:0]                  pc,
    output logic [PC_W-1:0]                  pc_next,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_full,
    output logic                             ras_empty,
    output logic                             halted,
    output logic [FAULT_W-1:0]               fault
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
`ifdef PC_SEQ_BOUNDS_EN
    localparam logic [PC_W-1:0] LIMIT_C = PC_W'(PC_LIMIT);
`endif

    pc_state_e           state_q;
    logic [PC_W-1:0]     pc_q;
    logic [FAULT_W-1:0]  fault_q;

    logic [PC_W-1:0]     pc_next_s;
    logic [PC_W-1:0]     pc_inc_s;
    logic [PC_W-1:0]     sext_s;
    logic [FAULT_W-1:0]  fault_set_s;
    logic                halt_s;
    logic                push_s;
    logic                pop_s;
    logic [PC_W-1:0]     ras_top_s;
    logic [CNT_W-1:0]    ras_count_s;
    logic                ras_full_s;
    logic                ras_empty_s;

    pc_ras #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (pc_inc_s),
        .data_o  (ras_top_s),
        .count_o (ras_count_s),
        .full_o  (ras_full_s),
        .empty_o (ras_empty_s)
    );

    // Next-PC selection, stack control and fault detection for the current op.
    always_comb begin
        pc_inc_s    = pc_q + PC_W'(1);
        sext_s      = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
        pc_next_s   = pc_q;
        fault_set_s = {FAULT_W{1'b0}};
        halt_s      = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        if ((state_q == RUN) && en) begin
            case (op)
                SEQ:  pc_next_s = pc_inc_s;
                JMP:  pc_next_s = target;
                BR:   pc_next_s = cond ? (pc_q + sext_s) : pc_inc_s;
                CALL: begin
                    pc_next_s = target;
                    if (ras_full_s) begin
                        fault_set_s[FAULT_OVF] = 1'b1;
                        halt_s                 = 1'b1;
                    end else begin
                        push_s = 1'b1;
                    end
                end
                RET: begin
                    if (ras_empty_s) begin
                        fault_set_s[FAULT_UNF] = 1'b1;
                        halt_s                 = 1'b1;
                    end else begin
                        pc_next_s = ras_top_s;
                        pop_s     = 1'b1;
                    end
                end
                default: pc_next_s = pc_q;
            endcase
`ifdef PC_SEQ_BOUNDS_EN
            // The out-of-range value is still loaded; the halt freezes it there.
            if (pc_next_s > LIMIT_C) begin
                fault_set_s[FAULT_BND] = 1'b1;
                halt_s                 = 1'b1;
            end else begin
                fault_set_s[FAULT_BND] = fault_set_s[FAULT_BND];
            end
`endif
        end else begin
            pc_next_s = pc_q;
        end
    end

    // Sequencer FSM: RUN advances on en, HALT freezes everything until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            pc_q    <= PC_W'(RESET_PC);
            fault_q <= {FAULT_W{1'b0}};
        end else begin
            case (state_q)
                RUN: begin
                    if (en) begin
                        pc_q    <= pc_next_s;
                        fault_q <= fault_q | fault_set_s;
                        state_q <= halt_s ? HALT : RUN;
                    end else begin
                        state_q <= RUN;
                    end
                end
                HALT:    state_q <= HALT;
                default: state_q <= HALT;
            endcase
        end
    end

    assign pc        = pc_q;
    assign pc_next   = pc_next_s;
    assign ras_count = ras_count_s;
    assign ras_full  = ras_full_s;
    assign ras_empty = ras_empty_s;
    assign halted    = (state_q == HALT);
    assign fault     = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-and-arithmetic reference model feeds expected state to a monitor.
// Honours PC_SEQ_BOUNDS_EN (PC_LIMIT=50) when defined.
module tb_pc_sequencer;

    localparam int PC_W   = 9;
    localparam int OFF_W  = 6;
    localparam int DEPTH  = 4;
    localparam int SPAN   = 1 << PC_W;
    localparam int OSPAN  = 1 << OFF_W;
`ifdef PC_SEQ_BOUNDS_EN
    localparam int FW     = 3;
    localparam int LIMIT  = 50;
`else
    localparam int FW     = 2;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic [2:0]       op = 3'd0;
    logic [PC_W-1:0]  target = '0;
    logic [OFF_W-1:0] offset = '0;
    logic             cond = 1'b0;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_next;
    logic [2:0]       ras_count;
    logic             ras_full;
    logic             ras_empty;
    logic             halted;
    logic [FW-1:0]    fault;

    pc_sequencer #(
        .PC_W      (PC_W),
        .OFF_W     (OFF_W),
        .RAS_DEPTH (DEPTH),
        .RESET_PC  (0)
`ifdef PC_SEQ_BOUNDS_EN
        ,
        .PC_LIMIT  (LIMIT)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .op        (op),
        .target    (target),
        .offset    (offset),
        .cond      (cond),
        .pc        (pc),
        .pc_next   (pc_next),
        .ras_count (ras_count),
        .ras_full  (ras_full),
        .ras_empty (ras_empty),
        .halted    (halted),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    pc;
        int    nxt;
        int    cnt;
        int    flt;
        bit    hlt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int   m_pc   = 0;
    int   m_ras[$];
    int   m_flt  = 0;
    bit   m_halt = 1'b0;

    task automatic chk(input string name, input string tag, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s [%s]: got %0d expected %0d", name, tag, act, expv);
        end
    endtask

    function automatic exp_t snapshot(input string tag, input int nxt);
        exp_t r;
        r.tag = tag;
        r.pc  = m_pc;
        r.nxt = nxt;
        r.cnt = m_ras.size();
        r.flt = m_flt;
        r.hlt = m_halt;
        return r;
    endfunction

    // Computes the value pc takes at the next edge and updates model state.
    task automatic model_step(input bit e, input int o, input int t, input int f, input bit c, output int nxt);
        int off;
        nxt = m_pc;
        if (!m_halt && e) begin
            case (o)
                0: nxt = (m_pc + 1) % SPAN;
                1: nxt = t;
                2: begin
                    off = (f >= OSPAN / 2) ? f - OSPAN : f;
                    nxt = c ? (m_pc + off + SPAN) % SPAN : (m_pc + 1) % SPAN;
                end
                3: begin
                    nxt = t;
                    if (m_ras.size() == DEPTH) begin
                        m_flt  = m_flt | 1;
                        m_halt = 1'b1;
                    end else begin
                        m_ras.push_back((m_pc + 1) % SPAN);
                    end
                end
                4: begin
                    if (m_ras.size() == 0) begin
                        m_flt  = m_flt | 2;
                        m_halt = 1'b1;
                    end else begin
                        nxt = m_ras.pop_back();
                    end
                end
                default: nxt = m_pc;
            endcase
`ifdef PC_SEQ_BOUNDS_EN
            if (nxt > LIMIT) begin
                m_flt  = m_flt | 4;
                m_halt = 1'b1;
            end
`endif
        end
        m_pc = nxt;
    endtask

    task automatic issue(input string tag, input bit e, input int o, input int t, input int f, input bit c);
        exp_t r;
        int   nxt;
        int   pre_pc;
        int   pre_cnt;
        int   pre_flt;
        bit   pre_hlt;
        @(posedge clk);
        #1;
        reset  = 1'b1;
        en     = e;
        op     = 3'(o);
        target = PC_W'(t);
        offset = OFF_W'(f);
        cond   = c;
        pre_pc  = m_pc;
        pre_cnt = m_ras.size();
        pre_flt = m_flt;
        pre_hlt = m_halt;
        model_step(e, o, t, f, c, nxt);
        r.tag = tag;
        r.pc  = pre_pc;
        r.nxt = nxt;
        r.cnt = pre_cnt;
        r.flt = pre_flt;
        r.hlt = pre_hlt;
        exp_q.push_back(r);
    endtask

    // Reset is asserted mid-cycle; the monitor samples before the next rising edge.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
        en    = 1'b0;
        op    = 3'd0;
        m_pc  = 0;
        m_ras.delete();
        m_flt  = 0;
        m_halt = 1'b0;
        exp_q.push_back(snapshot(tag, 0));
    endtask

    // Monitor: compares DUT outputs against the queued expectation each cycle.
    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk("pc",        r.tag, int'(pc),        r.pc);
                chk("pc_next",   r.tag, int'(pc_next),   r.nxt);
                chk("ras_count", r.tag, int'(ras_count), r.cnt);
                chk("ras_full",  r.tag, int'(ras_full),  (r.cnt == DEPTH) ? 1 : 0);
                chk("ras_empty", r.tag, int'(ras_empty), (r.cnt == 0) ? 1 : 0);
                chk("halted",    r.tag, int'(halted),    int'(r.hlt));
                chk("fault",     r.tag, int'(fault),     r.flt);
            end
        end
    end

    initial begin
        do_reset("reset");
        for (int i = 0; i < 4; i++) issue("seq", 1'b1, 0, 0, 0, 1'b0);
        issue("en_low", 1'b0, 0, 0, 0, 1'b0);
        issue("en_low2", 1'b1, 5, 0, 0, 1'b0);

        issue("jmp10", 1'b1, 1, 10, 0, 1'b0);
        issue("br_taken", 1'b1, 2, 0, 60, 1'b1);
        issue("br_not", 1'b1, 2, 0, 60, 1'b0);
        issue("jmp2", 1'b1, 1, 2, 0, 1'b0);
        issue("br_wrap", 1'b1, 2, 0, 60, 1'b1);
        issue("jmp1ff", 1'b1, 1, 511, 0, 1'b0);
        issue("seq_wrap", 1'b1, 0, 0, 0, 1'b0);
        issue("jmp5", 1'b1, 1, 5, 0, 1'b0);
        issue("call42", 1'b1, 3, 42, 0, 1'b0);
        issue("ret", 1'b1, 4, 0, 0, 1'b0);
        issue("hold", 1'b1, 7, 0, 0, 1'b0);

        for (int i = 0; i < 4; i++) issue("call_fill", 1'b1, 3, 8 + i, 0, 1'b0);
        issue("call_ovf", 1'b1, 3, 100, 0, 1'b0);
        issue("seq_halted", 1'b1, 0, 0, 0, 1'b0);
        issue("ret_halted", 1'b1, 4, 0, 0, 1'b0);

        do_reset("reset2");
        issue("ret_unf", 1'b1, 4, 0, 0, 1'b0);
        issue("seq_halted2", 1'b1, 0, 0, 0, 1'b0);
        issue("seq_halted3", 1'b1, 0, 0, 0, 1'b0);
        do_reset("async_reset");
        issue("jmp60", 1'b1, 1, 60, 0, 1'b0);
        issue("after60", 1'b1, 0, 0, 0, 1'b0);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset("rnd_reset");
            end else begin
                issue("random", ($urandom_range(0, 9) != 0), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, SPAN - 1)), int'($urandom_range(0, OSPAN - 1)),
                      1'($urandom_range(0, 1)));
            end
        end

        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", "end", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
